// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: walks active-low row drives, debounces a detected press
// and its release, and reports each accepted key once as row*4 + col.
module key_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 5000,
    parameter int unsigned DEB_CNT  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_busy
);

    localparam int unsigned DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_col_meta;
    logic [3:0]        r_col_s;
    logic [1:0]        r_row_idx;
    logic [1:0]        w_row_nxt;
    logic [DW_W-1:0]   r_dwell;
    logic [DW_W-1:0]   w_dwell_nxt;
    logic [DB_W-1:0]   r_deb;
    logic [DB_W-1:0]   w_deb_nxt;
    logic [3:0]        r_pat;
    logic [3:0]        w_pat_nxt;
    logic [1:0]        r_col_idx;
    logic [1:0]        w_col_idx_nxt;
    logic [3:0]        r_key_row;
    logic [3:0]        r_key_code;
    logic [3:0]        w_code_nxt;
    logic              r_key_valid;
    logic              w_valid_nxt;
    logic              r_key_busy;

    // Lowest-index low column wins when several columns are pulled low.
    function automatic logic [1:0] low_idx(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Two-flop synchronizer; idles at all-high like the pulled-up columns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= 4'hF;
            r_col_s    <= 4'hF;
        end else begin
            r_col_meta <= key_col;
            r_col_s    <= r_col_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_SCAN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row_idx;
        w_dwell_nxt   = r_dwell;
        w_deb_nxt     = r_deb;
        w_pat_nxt     = r_pat;
        w_col_idx_nxt = r_col_idx;
        w_code_nxt    = r_key_code;
        w_valid_nxt   = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell != DW_LAST) begin
                    w_dwell_nxt = r_dwell + DW_W'(1);
                end else begin
                    w_dwell_nxt = '0;
                    if (r_col_s == 4'hF) begin
                        w_row_nxt = r_row_idx + 2'd1;
                    end else begin
                        w_pat_nxt     = r_col_s;
                        w_col_idx_nxt = low_idx(r_col_s);
                        w_deb_nxt     = '0;
                        w_state_nxt   = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (r_col_s != r_pat) begin
                    w_deb_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_row_nxt   = r_row_idx + 2'd1;
                    w_state_nxt = ST_SCAN;
                end else if (r_deb == DB_LAST) begin
                    w_deb_nxt   = '0;
                    w_code_nxt  = {r_row_idx, r_col_idx};
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_deb_nxt = r_deb + DB_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_col_s == 4'hF) begin
                    w_deb_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (r_col_s != 4'hF) begin
                    w_deb_nxt = '0;
                end else if (r_deb == DB_LAST) begin
                    w_deb_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_row_nxt   = 2'd0;
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_deb_nxt = r_deb + DB_W'(1);
                end
            end
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    // Row drive and busy are registered from next-state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_idx   <= 2'd0;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_pat       <= 4'hF;
            r_col_idx   <= 2'd0;
            r_key_row   <= 4'b1110;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_busy  <= 1'b0;
        end else begin
            r_row_idx   <= w_row_nxt;
            r_dwell     <= w_dwell_nxt;
            r_deb       <= w_deb_nxt;
            r_pat       <= w_pat_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_key_row   <= ~(4'b0001 << w_row_nxt);
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_busy  <= (w_state_nxt != ST_SCAN);
        end
    end

    assign key_row   = r_key_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_busy  = r_key_busy;

endmodule

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 5000: clock cycles each row is driven during scanning (100 us at 50 MHz); legal range >= 2.
REQ-002 Parameter DEB_CNT, default 1000000: stable-input cycles required for press and release debounce (20 ms at 50 MHz); legal range >= 2.
REQ-003 clk  input  1  system clock; all flops clocked on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_col  input  4  keypad column lines; active-low, pulled up externally; asynchronous to clk.
REQ-006 key_row  output  4  keypad row drive; active-low; exactly one bit low at all times.
REQ-007 key_code  output  4  last accepted key, encoded as row*4 + col.
REQ-008 key_valid  output  1  one-cycle pulse when key_code is updated.
REQ-009 key_busy  output  1  high while a key is under debounce, held, or under release debounce.

Function
REQ-010 key_col SHALL pass through a 2-flop synchronizer (col_s); all decisions use col_s only.
REQ-011 States: SCAN, DEBOUNCE, HOLD, RELEASE; exactly one active.
REQ-012 SCAN: key_row = ~(1 << row_idx); dwell counter runs 0..SCAN_DIV-1.
REQ-013 SCAN, last dwell cycle, col_s == 4'hF: row_idx advances (3 wraps to 0), dwell counter clears.
REQ-014 SCAN, last dwell cycle, col_s != 4'hF: latch row_idx, col_s, and the column index (lowest-index low bit wins on multiple lows); enter DEBOUNCE with row held.
REQ-015 DEBOUNCE, col_s equals latched pattern: debounce counter increments.
REQ-016 DEBOUNCE, col_s differs from latched pattern: clear counter, advance row_idx (with wrap), return to SCAN; no key_valid.
REQ-017 DEBOUNCE, counter at DEB_CNT-1 with stable input: key_code <= row*4+col and key_valid = 1 in the same cycle; enter HOLD. key_valid therefore rises DEB_CNT cycles after DEBOUNCE entry.
REQ-018 HOLD: row held; no further key_valid however long the key is held; enter RELEASE when col_s == 4'hF.
REQ-019 RELEASE: counter increments while col_s == 4'hF; any low bit clears the counter and stays in RELEASE (no new event); at DEB_CNT-1, enter SCAN with row_idx = 0 and dwell counter cleared.
REQ-020 key_busy = 1 in DEBOUNCE, HOLD, RELEASE; 0 in SCAN.
REQ-021 key_code holds its value between key_valid pulses.
REQ-022 Counters sized for their maximum value; no overflow wrap in any state.
REQ-023 A key in a different row pressed while in DEBOUNCE/HOLD/RELEASE is ignored; only the latched row is observed.

Reset
REQ-024 On rst_n low, immediately and regardless of state: state = SCAN, row_idx = 0, key_row = 4'b1110, key_code = 4'h0, key_valid = 0, key_busy = 0, all counters 0, synchronizer flops = 4'hF.
REQ-025 After rst_n deasserts, the first dwell starts at row 0 on the next rising edge.

Verification (SCAN_DIV=4, DEB_CNT=16)
REQ-026 Idle, key_col = 4'hF -> key_row cycles 1110,1101,1011,0111,1110, each held 4 cycles; key_valid never high; key_busy = 0.
REQ-027 Key row 2 / col 1 pressed and held 200 cycles -> exactly one key_valid pulse with key_code = 4'd9, 16 cycles after DEBOUNCE entry; key_busy high from DEBOUNCE entry until release debounce completes.
REQ-028 Press bounces (col line toggles 5 cycles into DEBOUNCE) -> no key_valid; return to SCAN with row_idx advanced by one.
REQ-029 Row 1, col0 and col3 low together -> key_code = 4'd4.
REQ-030 Release bounce (key re-low 10 cycles after release, then clean) -> no second key_valid; scanning resumes at key_row = 1110 16 cycles after the final clean release.
REQ-031 rst_n pulsed low mid-DEBOUNCE -> all outputs at reset values in the same cycle; no key_valid after rst_n deasserts until a fresh full debounce.
